// File: rtl/intf2_wr_sched.sv
// Write-side scheduler for the 8-lane input interface: picks the source, drives the per-beat
// skew rotation and produces registered bank write enable/address for one frame of LEN+1 beats.
module intf2_wr_sched #(
    parameter int unsigned ADDR_W = 9
) (
    input  logic              CLK,
    input  logic              RSTN,
    input  logic              START,
    input  logic              MODE,
    input  logic [ADDR_W-1:0] LEN,
    input  logic              VLD_IN,
    output logic              RDY_OUT,
    output logic              SEL_EXTN,
    output logic [2:0]        SEL_PERMW,
    output logic              WEN,
    output logic [ADDR_W-1:0] WADDR,
    output logic              BUSY,
    output logic              DONE
);

    localparam int unsigned NumDigits = ADDR_W / 3;

    typedef enum logic [1:0] {StIdle, StRun, StLast} state_e;

    state_e            state_q, state_d;
    logic              mode_q, mode_d;
    logic [ADDR_W-1:0] len_q, len_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              wen_q, wen_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic              accept;
    logic [2:0]        perm;

    assign accept = (state_q == StRun) && VLD_IN;

    // Skewed bank mapping: rotation is the base-8 digit sum of the beat index, carries dropped.
    always_comb begin
        perm = 3'd0;
        for (int i = 0; i < NumDigits; i++) begin
            perm = perm + cnt_q[3*i +: 3];
        end
    end

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        wen_d   = accept;
        waddr_d = accept ? cnt_q : waddr_q;
        unique case (state_q)
            StIdle: begin
                if (START) begin
                    mode_d  = MODE;
                    len_d   = LEN;
                    cnt_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                if (accept) begin
                    if (cnt_q == len_q) begin
                        state_d = StLast;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            StLast: begin
                // Return CNT to zero so the idle rotation reads 0.
                cnt_d   = '0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q <= StIdle;
            mode_q  <= 1'b0;
            len_q   <= '0;
            cnt_q   <= '0;
            wen_q   <= 1'b0;
            waddr_q <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            wen_q   <= wen_d;
            waddr_q <= waddr_d;
        end
    end

    assign RDY_OUT   = (state_q == StRun);
    assign SEL_EXTN  = mode_q;
    assign SEL_PERMW = perm;
    assign WEN       = wen_q;
    assign WADDR     = waddr_q;
    assign BUSY      = (state_q != StIdle);
    assign DONE      = (state_q == StLast);

endmodule

// File: tb/tb_intf2_wr_sched.sv
// Self-checking bench for intf2_wr_sched: cycle model plus write-address scoreboard,
// a hand-derived vector table for a gapped frame, and directed corner sequences.
module tb_intf2_wr_sched;

    localparam int ADDR_W = 9;

    logic              CLK = 1'b0;
    logic              RSTN;
    logic              START;
    logic              MODE;
    logic [ADDR_W-1:0] LEN;
    logic              VLD_IN;
    logic              RDY_OUT;
    logic              SEL_EXTN;
    logic [2:0]        SEL_PERMW;
    logic              WEN;
    logic [ADDR_W-1:0] WADDR;
    logic              BUSY;
    logic              DONE;

    intf2_wr_sched #(.ADDR_W(ADDR_W)) dut (
        .CLK      (CLK),
        .RSTN     (RSTN),
        .START    (START),
        .MODE     (MODE),
        .LEN      (LEN),
        .VLD_IN   (VLD_IN),
        .RDY_OUT  (RDY_OUT),
        .SEL_EXTN (SEL_EXTN),
        .SEL_PERMW(SEL_PERMW),
        .WEN      (WEN),
        .WADDR    (WADDR),
        .BUSY     (BUSY),
        .DONE     (DONE)
    );

    always #5 CLK = ~CLK;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model state.
    int m_st   = 0;  // 0 idle, 1 run, 2 last
    int m_cnt  = 0;
    int m_len  = 0;
    int m_mode = 0;
    int m_wen  = 0;
    int exp_q[$];

    // Snapshot of DUT outputs taken in the middle of the last stepped cycle.
    int s_rdy, s_wen, s_waddr, s_done, s_busy, s_perm, s_extn;
    int wen_cnt, done_cnt, done_waddr;
    int perm_at[512];

    typedef struct {
        logic start;
        logic vld;
        int   rdy;
        int   wen;
        int   waddr;
        int   done;
        int   busy;
        int   perm;
    } vec_t;
    vec_t vt[10];

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    function automatic int digsum(input int c);
        return (c % 8 + (c / 8) % 8 + (c / 64) % 8) % 8;
    endfunction

    task automatic model_reset();
        m_st = 0; m_cnt = 0; m_len = 0; m_mode = 0; m_wen = 0;
        exp_q.delete();
    endtask

    task automatic step(input logic s, input logic m, input int l, input logic v);
        int acc;
        int e;
        @(negedge CLK);
        START = s; MODE = m; LEN = ADDR_W'(l); VLD_IN = v;
        #1;
        s_rdy = int'(RDY_OUT); s_wen = int'(WEN); s_waddr = int'(WADDR);
        s_done = int'(DONE); s_busy = int'(BUSY); s_perm = int'(SEL_PERMW);
        s_extn = int'(SEL_EXTN);
        chk("rdy", s_rdy, (m_st == 1) ? 1 : 0);
        chk("busy", s_busy, (m_st != 0) ? 1 : 0);
        chk("done", s_done, (m_st == 2) ? 1 : 0);
        chk("sel_extn", s_extn, m_mode);
        chk("sel_permw", s_perm, digsum(m_cnt));
        chk("wen", s_wen, m_wen);
        if (m_wen != 0) begin
            if (exp_q.size() == 0) chk("sb_underflow", 1, 0);
            else begin
                e = exp_q.pop_front();
                chk("waddr", s_waddr, e);
            end
        end
        if (s_wen != 0) wen_cnt++;
        if (s_done != 0) begin
            done_cnt++;
            done_waddr = s_waddr;
        end
        if (m_st == 1 && m_cnt < 512) perm_at[m_cnt] = s_perm;
        @(posedge CLK);
        acc = (m_st == 1 && v) ? 1 : 0;
        m_wen = acc;
        if (acc != 0) exp_q.push_back(m_cnt);
        case (m_st)
            0: if (s) begin m_mode = int'(m); m_len = l; m_cnt = 0; m_st = 1; end
            1: if (acc != 0) begin
                if (m_cnt == m_len) m_st = 2;
                else m_cnt++;
            end
            default: begin m_st = 0; m_cnt = 0; end
        endcase
    endtask

    task automatic clr_counts();
        wen_cnt = 0; done_cnt = 0; done_waddr = -1;
    endtask

    initial begin
        // Hand-derived: LEN=3, VLD pattern 1,0,0,1,1,0,1 after START.
        //          start vld  rdy wen waddr done busy perm
        vt[0] = '{1'b1, 1'b0, 0, 0, -1, 0, 0, 0};
        vt[1] = '{1'b0, 1'b1, 1, 0, -1, 0, 1, 0};
        vt[2] = '{1'b0, 1'b0, 1, 1,  0, 0, 1, 1};
        vt[3] = '{1'b0, 1'b0, 1, 0, -1, 0, 1, 1};
        vt[4] = '{1'b0, 1'b1, 1, 0, -1, 0, 1, 1};
        vt[5] = '{1'b0, 1'b1, 1, 1,  1, 0, 1, 2};
        vt[6] = '{1'b0, 1'b0, 1, 1,  2, 0, 1, 3};
        vt[7] = '{1'b0, 1'b1, 1, 0, -1, 0, 1, 3};
        vt[8] = '{1'b0, 1'b0, 0, 1,  3, 1, 1, 3};
        vt[9] = '{1'b0, 1'b0, 0, 0, -1, 0, 0, 0};

        RSTN = 1'b0; START = 1'b0; MODE = 1'b0; LEN = '0; VLD_IN = 1'b0;
        model_reset();
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_rdy", int'(RDY_OUT), 0);
        chk("rst_wen", int'(WEN), 0);
        chk("rst_waddr", int'(WADDR), 0);
        chk("rst_busy", int'(BUSY), 0);
        chk("rst_done", int'(DONE), 0);
        chk("rst_perm", int'(SEL_PERMW), 0);
        @(negedge CLK);
        RSTN = 1'b1;

        // LEN=7, continuous valid.
        clr_counts();
        step(1'b1, 1'b0, 7, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 0, 1'b1);
        chk("len7_wen_pulses", wen_cnt, 8);
        chk("len7_done_pulses", done_cnt, 1);
        chk("len7_done_waddr", done_waddr, 7);
        for (int i = 0; i < 8; i++) chk("len7_perm", perm_at[i], i);

        // LEN=511, HRMF, continuous valid.
        clr_counts();
        step(1'b1, 1'b1, 511, 1'b0);
        for (int i = 0; i < 515; i++) step(1'b0, 1'b0, 0, 1'b1);
        chk("full_wen_pulses", wen_cnt, 512);
        chk("full_done_pulses", done_cnt, 1);
        chk("perm_cnt8", perm_at[8], 1);
        chk("perm_cnt9", perm_at[9], 2);
        chk("perm_cnt63", perm_at[63], 6);
        chk("perm_cnt511", perm_at[511], 5);
        chk("idle_extn_held", s_extn, 1);

        // Table: gapped LEN=3 frame.
        for (int i = 0; i < 10; i++) begin
            step(vt[i].start, 1'b0, 3, vt[i].vld);
            chk("tbl_rdy", s_rdy, vt[i].rdy);
            chk("tbl_wen", s_wen, vt[i].wen);
            if (vt[i].wen != 0) chk("tbl_waddr", s_waddr, vt[i].waddr);
            chk("tbl_done", s_done, vt[i].done);
            chk("tbl_busy", s_busy, vt[i].busy);
            chk("tbl_perm", s_perm, vt[i].perm);
        end

        // LEN=0: single beat; WEN and DONE coincide.
        clr_counts();
        step(1'b1, 1'b0, 0, 1'b0);
        step(1'b0, 1'b0, 0, 1'b1);
        step(1'b0, 1'b0, 0, 1'b0);
        chk("len0_wen_with_done", s_wen, 1);
        chk("len0_done", s_done, 1);
        chk("len0_waddr", s_waddr, 0);
        step(1'b0, 1'b0, 0, 1'b0);
        chk("len0_wen_pulses", wen_cnt, 1);

        // START during RUN and during LAST is ignored.
        clr_counts();
        step(1'b1, 1'b0, 5, 1'b0);
        step(1'b0, 1'b0, 0, 1'b1);
        step(1'b0, 1'b0, 0, 1'b1);
        step(1'b1, 1'b1, 2, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 0, 1'b1);
        step(1'b1, 1'b1, 2, 1'b0);
        chk("restart_in_last_done", s_done, 1);
        step(1'b0, 1'b0, 0, 1'b0);
        step(1'b0, 1'b0, 0, 1'b0);
        chk("restart_wen_pulses", wen_cnt, 6);
        chk("restart_done_waddr", done_waddr, 5);
        chk("restart_extn", s_extn, 0);

        // Asynchronous reset mid-frame at CNT=4 of LEN=15.
        clr_counts();
        step(1'b1, 1'b1, 15, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 0, 1'b1);
        #2;
        RSTN = 1'b0;
        #1;
        chk("arst_rdy", int'(RDY_OUT), 0);
        chk("arst_busy", int'(BUSY), 0);
        chk("arst_wen", int'(WEN), 0);
        chk("arst_waddr", int'(WADDR), 0);
        chk("arst_extn", int'(SEL_EXTN), 0);
        chk("arst_perm", int'(SEL_PERMW), 0);
        chk("arst_done", int'(DONE), 0);
        model_reset();
        @(negedge CLK);
        RSTN = 1'b1;
        step(1'b0, 1'b0, 0, 1'b1);
        chk("arst_no_done", done_cnt, 0);
        clr_counts();
        step(1'b1, 1'b1, 15, 1'b0);
        for (int i = 0; i < 19; i++) step(1'b0, 1'b0, 0, 1'b1);
        chk("post_rst_wen_pulses", wen_cnt, 16);
        chk("post_rst_done_waddr", done_waddr, 15);
        chk("post_rst_done_pulses", done_cnt, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
